// File: rtl/fifo_mem_prog.sv
// fifo_mem_prog
// -------------
// Synchronous FIFO for any depth >= 2, with a live occupancy count,
// run-time programmable almost-full/almost-empty thresholds, sticky
// overflow/underflow flags with explicit clear, and an optional
// first-word-fall-through (FWFT) read mode.
//
// Build option:
//   FIFO_FWFT_EN  defined   -> data_out shows mem[rd_ptr] combinationally,
//                              data_valid = !empty_ind, trans_read pops the
//                              word on display.
//                 undefined -> registered read: data_out loads on an accepted
//                              read, data_valid pulses one cycle later.
//
// Ports:
//   clk_in            clock, all logic on the rising edge
//   sreset            synchronous active-high reset
//   trans_write       write request, data_in captured when accepted
//   trans_read        read request
//   data_in           write data
//   af_level          almost-full threshold  (fill_count >= af_level)
//   ae_level          almost-empty threshold (fill_count <= ae_level)
//   err_clear         clears overflow_ind / underflow_ind
//   data_out          read data
//   data_valid        data_out qualifier
//   fill_count        occupancy, 0..DEPTH
//   full_ind          fill_count == DEPTH
//   empty_ind         fill_count == 0
//   almost_full_ind   fill_count >= af_level
//   almost_empty_ind  fill_count <= ae_level
//   overflow_ind      sticky: a write was rejected
//   underflow_ind     sticky: a read was rejected
//
// Handshake: a request is a single-cycle strobe with no back-pressure
// signal of its own; the producer watches full_ind and the consumer
// watches empty_ind (or data_valid in FWFT mode). A write is accepted when
// the FIFO is not full or a read is accepted in the same cycle; a read is
// accepted when the FIFO is not empty. A rejected request is dropped and
// recorded in the matching sticky error flag.

module fifo_mem_prog #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 6,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk_in,
    input  logic                  sreset,
    input  logic                  trans_write,
    input  logic                  trans_read,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0]      af_level,
    input  logic [CNT_W-1:0]      ae_level,
    input  logic                  err_clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [CNT_W-1:0]      fill_count,
    output logic                  full_ind,
    output logic                  empty_ind,
    output logic                  almost_full_ind,
    output logic                  almost_empty_ind,
    output logic                  overflow_ind,
    output logic                  underflow_ind
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ovf_q;
    logic                  udf_q;

    // Status decode from the registered count.
    assign fill_count       = count_q;
    assign full_ind         = (count_q == FULL_CNT);
    assign empty_ind        = (count_q == '0);
    // Unsigned compares give the forced cases for free: af_level = 0 is
    // always met, and ae_level >= DEPTH is always met since count <= DEPTH.
    assign almost_full_ind  = (count_q >= af_level);
    assign almost_empty_ind = (count_q <= ae_level);
    assign overflow_ind     = ovf_q;
    assign underflow_ind    = udf_q;

    // Read is judged first so a write into a full FIFO can ride on it.
    // An empty FIFO never bypasses a same-cycle write to the reader.
    assign rd_acc = trans_read && !empty_ind;
    assign wr_acc = trans_write && (!full_ind || rd_acc);

    // Storage is deliberately not reset; only the write strobe is gated.
    always_ff @(posedge clk_in) begin
        if (!sreset && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    always_ff @(posedge clk_in) begin
        if (sreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    // Acceptance rules keep the count inside 0..DEPTH without clamping.
    always_ff @(posedge clk_in) begin
        if (sreset) begin
            count_q <= '0;
        end else if (wr_acc && !rd_acc) begin
            count_q <= count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Sticky errors: a new rejection in the same cycle beats err_clear.
    always_ff @(posedge clk_in) begin
        if (sreset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (trans_write && !wr_acc) begin
                ovf_q <= 1'b1;
            end else if (err_clear) begin
                ovf_q <= 1'b0;
            end
            if (trans_read && !rd_acc) begin
                udf_q <= 1'b1;
            end else if (err_clear) begin
                udf_q <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head of queue is always on display; a read simply advances rd_ptr.
    assign data_out   = mem[rd_ptr];
    assign data_valid = !empty_ind;
`else
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dvalid_q;

    // data_out holds its last value between reads; data_valid is a
    // one-cycle pulse following each accepted read.
    always_ff @(posedge clk_in) begin
        if (sreset) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dvalid_q <= rd_acc;
            if (rd_acc) begin
                dout_q <= mem[rd_ptr];
            end
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dvalid_q;
`endif

endmodule

// File: tb/tb_fifo_mem_prog.sv
// tb_fifo_mem_prog
// ----------------
// Self-checking bench for fifo_mem_prog (DATA_WIDTH = 8, DEPTH = 6).
// A queue-based reference model tracks contents, sticky flags and the
// expected read data; a hand-filled vector table covers fill/drain, full
// simultaneous access and error handling; short sequences cover wrap,
// overflow clear priority and reset; a random phase finishes the run.
// Works for both the default build and FIFO_FWFT_EN.

module tb_fifo_mem_prog;

    localparam int DW    = 8;
    localparam int DEPTH = 6;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // ---------------- clock / reset / DUT ----------------
    logic             clk_in = 1'b0;
    logic             sreset = 1'b0;
    logic             trans_write = 1'b0;
    logic             trans_read = 1'b0;
    logic [DW-1:0]    data_in = '0;
    logic [CNT_W-1:0] af_level = CNT_W'(5);
    logic [CNT_W-1:0] ae_level = CNT_W'(1);
    logic             err_clear = 1'b0;
    logic [DW-1:0]    data_out;
    logic             data_valid;
    logic [CNT_W-1:0] fill_count;
    logic             full_ind;
    logic             empty_ind;
    logic             almost_full_ind;
    logic             almost_empty_ind;
    logic             overflow_ind;
    logic             underflow_ind;

    always #5 clk_in = ~clk_in;

    fifo_mem_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_in           (clk_in),
        .sreset           (sreset),
        .trans_write      (trans_write),
        .trans_read       (trans_read),
        .data_in          (data_in),
        .af_level         (af_level),
        .ae_level         (ae_level),
        .err_clear        (err_clear),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .fill_count       (fill_count),
        .full_ind         (full_ind),
        .empty_ind        (empty_ind),
        .almost_full_ind  (almost_full_ind),
        .almost_empty_ind (almost_empty_ind),
        .overflow_ind     (overflow_ind),
        .underflow_ind    (underflow_ind)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_dv   = 1'b0;
    logic          m_ovf  = 1'b0;
    logic          m_udf  = 1'b0;

    int total = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model one clock edge from the FIFO's rules: a queue of stored words.
    task automatic model_step(input logic w, input logic r, input logic [DW-1:0] d,
                              input logic clr, input logic rst);
        logic rd_ok;
        logic wr_ok;
        if (rst) begin
            exp_q.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            rd_ok = r && (exp_q.size() > 0);
            wr_ok = w && ((exp_q.size() < DEPTH) || rd_ok);
            m_dv  = rd_ok;
            if (rd_ok) m_dout = exp_q.pop_front();
            if (wr_ok) exp_q.push_back(d);
            m_ovf = (w && !wr_ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_udf = (r && !rd_ok) ? 1'b1 : (clr ? 1'b0 : m_udf);
        end
    endtask

    task automatic check_model();
        int n;
        n = exp_q.size();
        chk("fill_count", 32'(fill_count), 32'(n));
        chk("full_ind", 32'(full_ind), 32'(n == DEPTH));
        chk("empty_ind", 32'(empty_ind), 32'(n == 0));
        chk("almost_full_ind", 32'(almost_full_ind), 32'(n >= int'(af_level)));
        chk("almost_empty_ind", 32'(almost_empty_ind), 32'(n <= int'(ae_level)));
        chk("overflow_ind", 32'(overflow_ind), 32'(m_ovf));
        chk("underflow_ind", 32'(underflow_ind), 32'(m_udf));
`ifdef FIFO_FWFT_EN
        chk("data_valid", 32'(data_valid), 32'(n != 0));
        if (n != 0) chk("data_out", 32'(data_out), 32'(exp_q[0]));
`else
        chk("data_valid", 32'(data_valid), 32'(m_dv));
        chk("data_out", 32'(data_out), 32'(m_dout));
`endif
    endtask

    // ---------------- driver ----------------
    task automatic do_cycle(input logic w, input logic r, input logic [DW-1:0] d,
                            input logic clr, input logic rst);
        trans_write = w;
        trans_read  = r;
        data_in     = d;
        err_clear   = clr;
        sreset      = rst;
        model_step(w, r, d, clr, rst);
        @(posedge clk_in);
        #1;
        trans_write = 1'b0;
        trans_read  = 1'b0;
        err_clear   = 1'b0;
        sreset      = 1'b0;
        check_model();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          w;
        logic          r;
        logic [DW-1:0] d;
        logic          clr;
        int            exp_cnt;
        logic          exp_dv;
        logic [DW-1:0] exp_dout;
        logic          exp_ovf;
        logic          exp_udf;
    } vec_t;

    function automatic vec_t mk(logic w, logic r, logic [DW-1:0] d, logic clr, int cnt,
                                logic dv, logic [DW-1:0] dout, logic ovf, logic udf);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.clr = clr;
        v.exp_cnt = cnt; v.exp_dv = dv; v.exp_dout = dout;
        v.exp_ovf = ovf; v.exp_udf = udf;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        // Fill 0x10..0x15, full simultaneous with 0xAA, drain, underflow, clear.
        tbl[0]  = mk(1, 0, 8'h10, 0, 1, 0, 8'h00, 0, 0);
        tbl[1]  = mk(1, 0, 8'h11, 0, 2, 0, 8'h00, 0, 0);
        tbl[2]  = mk(1, 0, 8'h12, 0, 3, 0, 8'h00, 0, 0);
        tbl[3]  = mk(1, 0, 8'h13, 0, 4, 0, 8'h00, 0, 0);
        tbl[4]  = mk(1, 0, 8'h14, 0, 5, 0, 8'h00, 0, 0);
        tbl[5]  = mk(1, 0, 8'h15, 0, 6, 0, 8'h00, 0, 0);
        tbl[6]  = mk(1, 1, 8'hAA, 0, 6, 1, 8'h10, 0, 0);
        tbl[7]  = mk(0, 1, 8'h00, 0, 5, 1, 8'h11, 0, 0);
        tbl[8]  = mk(0, 1, 8'h00, 0, 4, 1, 8'h12, 0, 0);
        tbl[9]  = mk(0, 1, 8'h00, 0, 3, 1, 8'h13, 0, 0);
        tbl[10] = mk(0, 1, 8'h00, 0, 2, 1, 8'h14, 0, 0);
        tbl[11] = mk(0, 1, 8'h00, 0, 1, 1, 8'h15, 0, 0);
        tbl[12] = mk(0, 1, 8'h00, 0, 0, 1, 8'hAA, 0, 0);
        tbl[13] = mk(0, 0, 8'h00, 0, 0, 0, 8'hAA, 0, 0);
        tbl[14] = mk(0, 1, 8'h00, 0, 0, 0, 8'hAA, 0, 1);
        tbl[15] = mk(0, 0, 8'h00, 0, 0, 0, 8'hAA, 0, 1);
        tbl[16] = mk(0, 0, 8'h00, 1, 0, 0, 8'hAA, 0, 0);
    end

    // ---------------- test sequence ----------------
    initial begin
        #1;
        // Reset state
        do_cycle(0, 0, 8'h00, 0, 1);
        chk("rst_empty", 32'(empty_ind), 32'd1);
        chk("rst_almost_empty", 32'(almost_empty_ind), 32'd1);
        chk("rst_full", 32'(full_ind), 32'd0);

        // Table-driven fill / drain / full simultaneous / underflow
        for (int i = 0; i < 17; i++) begin
            do_cycle(tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].clr, 1'b0);
            chk($sformatf("tbl%0d_cnt", i), 32'(fill_count), 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow_ind), 32'(tbl[i].exp_ovf));
            chk($sformatf("tbl%0d_udf", i), 32'(underflow_ind), 32'(tbl[i].exp_udf));
`ifndef FIFO_FWFT_EN
            chk($sformatf("tbl%0d_dv", i), 32'(data_valid), 32'(tbl[i].exp_dv));
            chk($sformatf("tbl%0d_dout", i), 32'(data_out), 32'(tbl[i].exp_dout));
`endif
            if (i == 4) chk("af_at_5", 32'(almost_full_ind), 32'd1);
            if (i == 3) chk("af_at_4", 32'(almost_full_ind), 32'd0);
        end

        // Wrap: 20 write/read pairs, data 0x00..0x13
        for (int i = 0; i < 20; i++) begin
            do_cycle(1, 0, 8'(i), 0, 0);
`ifdef FIFO_FWFT_EN
            chk("fwft_show", 32'(data_out), 32'(i));
            chk("fwft_valid", 32'(data_valid), 32'd1);
`endif
            do_cycle(0, 1, 8'h00, 0, 0);
`ifndef FIFO_FWFT_EN
            chk("wrap_dout", 32'(data_out), 32'(i));
`else
            chk("fwft_pop_valid", 32'(data_valid), 32'd0);
`endif
            chk("wrap_empty", 32'(empty_ind), 32'd1);
        end

        // Overflow stickiness and set-beats-clear
        for (int i = 0; i < DEPTH; i++) do_cycle(1, 0, 8'(8'h40 + i), 0, 0);
        do_cycle(1, 0, 8'hEE, 0, 0);
        chk("ovf_set", 32'(overflow_ind), 32'd1);
        do_cycle(0, 0, 8'h00, 0, 0);
        chk("ovf_hold", 32'(overflow_ind), 32'd1);
        do_cycle(1, 0, 8'hEF, 1, 0);
        chk("ovf_set_beats_clr", 32'(overflow_ind), 32'd1);
        do_cycle(0, 0, 8'h00, 1, 0);
        chk("ovf_clr", 32'(overflow_ind), 32'd0);

        // Reset mid-operation at count 3 with a concurrent write
        for (int i = 0; i < DEPTH - 3; i++) do_cycle(0, 1, 8'h00, 0, 0);
        do_cycle(1, 0, 8'hEE, 0, 0);   // overflow at count 3? no: accepted
        do_cycle(0, 1, 8'h00, 0, 0);   // back to 3
        do_cycle(1, 1, 8'h00, 0, 0);   // keep 3 and exercise both
        chk("pre_rst_cnt", 32'(fill_count), 32'd3);
        do_cycle(1, 0, 8'h99, 0, 1);
        chk("rst_cnt", 32'(fill_count), 32'd0);
        chk("rst_empty2", 32'(empty_ind), 32'd1);
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_ovf", 32'(overflow_ind), 32'd0);
        chk("rst_udf", 32'(underflow_ind), 32'd0);

        // Threshold corners: af_level = 0 forces almost_full, ae >= DEPTH forces almost_empty
        af_level = '0;
        ae_level = CNT_W'(DEPTH);
        #1;
        chk("af_zero", 32'(almost_full_ind), 32'd1);
        for (int i = 0; i < DEPTH; i++) do_cycle(1, 0, 8'(i), 0, 0);
        chk("ae_ge_depth_full", 32'(almost_empty_ind), 32'd1);
        do_cycle(0, 0, 8'h00, 0, 1);

        // Randomized phase against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                af_level = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
                ae_level = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
            end
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
